// File: rtl/ll_ctrl_if.sv
// ----------------------------------------------------------------------------
// ll_ctrl_if
// Bundles the three buses around the line-length sequencing controller:
//   - sample stream in  : s_valid, s_ready, s_data
//   - datapath control  : feat_en (active-low), feat_rst, feat_din,
//                         feat_dout, feat_valid
//   - result stream out : res_valid, res_ready, res_feat, res_detect
// modport slave  : view taken by the controller (ll_ctrl)
// modport master : view taken by the surrounding front end / datapath / sink
// ----------------------------------------------------------------------------
interface ll_ctrl_if #(
  parameter int DATA_W = 16,
  parameter int FEAT_W = 25
);
  logic                     s_valid;
  logic                     s_ready;
  logic signed [DATA_W-1:0] s_data;

  logic                     feat_en;
  logic                     feat_rst;
  logic signed [DATA_W-1:0] feat_din;
  logic signed [FEAT_W-1:0] feat_dout;
  logic                     feat_valid;

  logic                     res_valid;
  logic                     res_ready;
  logic signed [FEAT_W-1:0] res_feat;
  logic                     res_detect;

  modport slave (
    input  s_valid, s_data, feat_dout, feat_valid, res_ready,
    output s_ready, feat_en, feat_rst, feat_din, res_valid, res_feat, res_detect
  );

  modport master (
    output s_valid, s_data, feat_dout, feat_valid, res_ready,
    input  s_ready, feat_en, feat_rst, feat_din, res_valid, res_feat, res_detect
  );
endinterface

// File: rtl/ll_ctrl.sv
// ----------------------------------------------------------------------------
// ll_ctrl
// Sequencing controller for the line-length feature datapath. Accepts a
// valid/ready sample stream, pulses the datapath's active-low enable once per
// accepted sample, counts samples into WIN_LEN windows, waits PIPE_LAT cycles
// after each window, captures the feature and compares it with a signed
// threshold, and offers the result on a valid/ready port.
// Ports:
//   clk, rst   : clock, synchronous active-high reset
//   start      : pulse, begins streaming from IDLE
//   stop       : pulse, latched, honoured at the next window capture
//   threshold  : signed detection threshold, sampled at capture
//   bus        : ll_ctrl_if.slave (sample in, datapath control, result out)
//   busy       : high whenever not IDLE
//   overrun    : sticky, a held result was overwritten before acceptance
// ----------------------------------------------------------------------------
module ll_ctrl #(
  parameter int DATA_W   = 16,
  parameter int FEAT_W   = 25,
  parameter int WIN_LEN  = 50,
  parameter int PIPE_LAT = 2,
  parameter int CNT_W    = 6
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     stop,
  input  logic signed [FEAT_W-1:0] threshold,
  ll_ctrl_if.slave                 bus,
  output logic                     busy,
  output logic                     overrun
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CLEAR = 3'd1;
  localparam logic [2:0] S_RUN   = 3'd2;
  localparam logic [2:0] S_DRAIN = 3'd3;
  localparam logic [2:0] S_CAPT  = 3'd4;

  localparam int LAT_W = (PIPE_LAT > 1) ? $clog2(PIPE_LAT) : 1;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN_LEN - 1);
  localparam logic [LAT_W-1:0] LAT_ZERO = {LAT_W{1'b0}};
  localparam logic [LAT_W-1:0] LAT_ONE  = {{(LAT_W-1){1'b0}}, 1'b1};
  localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(PIPE_LAT - 1);

  logic [2:0]               state_q, state_d;
  logic [CNT_W-1:0]         cnt_q, cnt_d;
  logic [LAT_W-1:0]         lat_q, lat_d;
  logic                     stop_q, stop_d;
  logic                     s_ready_q, s_ready_d;
  logic                     feat_rst_q, feat_rst_d;
  logic signed [DATA_W-1:0] feat_din_q, feat_din_d;
  logic                     res_valid_q, res_valid_d;
  logic signed [FEAT_W-1:0] res_feat_q, res_feat_d;
  logic                     res_detect_q, res_detect_d;
  logic                     busy_q, busy_d;
  logic                     overrun_q, overrun_d;

  logic accept_s;
  logic capture_s;

  // s_ready_q is high exactly while in RUN, so it doubles as the RUN qualifier.
  assign accept_s  = bus.s_valid & s_ready_q;
  assign capture_s = (state_q == S_CAPT) & bus.feat_valid;

  // Next-state, sample counter, drain counter and stop latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    lat_d   = lat_q;
    stop_d  = stop_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_CLEAR;
          cnt_d   = CNT_ZERO;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CLEAR: begin
        // The clear drops any old stop, but a stop arriving now is kept.
        stop_d  = stop;
        cnt_d   = CNT_ZERO;
        lat_d   = LAT_ZERO;
        state_d = S_RUN;
      end
      S_RUN: begin
        stop_d = stop_q | stop;
        if (accept_s) begin
          if (cnt_q == CNT_LAST) begin
            cnt_d   = CNT_ZERO;
            lat_d   = LAT_ZERO;
            state_d = S_DRAIN;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          cnt_d = cnt_q;
        end
      end
      S_DRAIN: begin
        stop_d = stop_q | stop;
        if (lat_q == LAT_LAST) begin
          lat_d   = LAT_ZERO;
          state_d = S_CAPT;
        end else begin
          lat_d = lat_q + LAT_ONE;
        end
      end
      S_CAPT: begin
        stop_d = stop_q | stop;
        if (stop_q) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_RUN;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = CNT_ZERO;
        lat_d   = LAT_ZERO;
        stop_d  = 1'b0;
      end
    endcase
  end

  // Registered status outputs derived from the upcoming state, plus result
  // capture / handshake and the sticky overrun flag.
  always_comb begin
    s_ready_d    = (state_d == S_RUN);
    feat_rst_d   = (state_d == S_CLEAR);
    busy_d       = (state_d != S_IDLE);
    feat_din_d   = accept_s ? bus.s_data : feat_din_q;
    res_valid_d  = res_valid_q;
    res_feat_d   = res_feat_q;
    res_detect_d = res_detect_q;
    overrun_d    = overrun_q;
    if (capture_s) begin
      // A capture wins over a same-cycle handshake; only an unaccepted
      // held result counts as overrun.
      res_valid_d  = 1'b1;
      res_feat_d   = bus.feat_dout;
      res_detect_d = (bus.feat_dout > threshold);
      overrun_d    = overrun_q | (res_valid_q & ~bus.res_ready);
    end else if (res_valid_q && bus.res_ready) begin
      res_valid_d = 1'b0;
    end else begin
      res_valid_d = res_valid_q;
    end
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      cnt_q        <= CNT_ZERO;
      lat_q        <= LAT_ZERO;
      stop_q       <= 1'b0;
      s_ready_q    <= 1'b0;
      feat_rst_q   <= 1'b0;
      feat_din_q   <= {DATA_W{1'b0}};
      res_valid_q  <= 1'b0;
      res_feat_q   <= {FEAT_W{1'b0}};
      res_detect_q <= 1'b0;
      busy_q       <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lat_q        <= lat_d;
      stop_q       <= stop_d;
      s_ready_q    <= s_ready_d;
      feat_rst_q   <= feat_rst_d;
      feat_din_q   <= feat_din_d;
      res_valid_q  <= res_valid_d;
      res_feat_q   <= res_feat_d;
      res_detect_q <= res_detect_d;
      busy_q       <= busy_d;
      overrun_q    <= overrun_d;
    end
  end

  // The enable and data strobe must land in the accept cycle itself, so they
  // are steered straight from the handshake; feat_din holds between samples.
  assign bus.s_ready    = s_ready_q;
  assign bus.feat_en    = ~accept_s;
  assign bus.feat_rst   = feat_rst_q;
  assign bus.feat_din   = accept_s ? bus.s_data : feat_din_q;
  assign bus.res_valid  = res_valid_q;
  assign bus.res_feat   = res_feat_q;
  assign bus.res_detect = res_detect_q;
  assign busy           = busy_q;
  assign overrun        = overrun_q;

endmodule

// File: tb/tb_ll_ctrl.sv
// ----------------------------------------------------------------------------
// tb_ll_ctrl
// Directed, table-driven bench for ll_ctrl with WIN_LEN=4, PIPE_LAT=2.
// Each record holds one cycle of inputs and the outputs expected during that
// cycle (before the next rising edge).
// ----------------------------------------------------------------------------
module tb_ll_ctrl;

  localparam int DATA_W = 16;
  localparam int FEAT_W = 25;

  logic clk;
  logic rst;
  logic start;
  logic stop;
  logic signed [FEAT_W-1:0] threshold;
  logic busy;
  logic overrun;

  int n_cmp;
  int n_bad;

  ll_ctrl_if #(.DATA_W(DATA_W), .FEAT_W(FEAT_W)) bus ();

  ll_ctrl #(
    .DATA_W  (DATA_W),
    .FEAT_W  (FEAT_W),
    .WIN_LEN (4),
    .PIPE_LAT(2),
    .CNT_W   (3)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .stop     (stop),
    .threshold(threshold),
    .bus      (bus),
    .busy     (busy),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic              rst;
    logic              start;
    logic              stop;
    logic              sv;
    logic [DATA_W-1:0] sd;
    logic              rr;
    logic [FEAT_W-1:0] fd;
    logic              fv;
    logic [FEAT_W-1:0] thr;
    logic              srdy;
    logic              fen;
    logic              frst;
    logic [DATA_W-1:0] fdin;
    logic              rv;
    logic [FEAT_W-1:0] rf;
    logic              rd;
    logic              bsy;
    logic              ovr;
  } vec_t;

  vec_t vec [36];

  function automatic vec_t mk(input int rs, st, sp, sv, sd, rr, fd, fv, th,
                              srdy, fen, frst, fdin, rv, rf, rd, bsy, ov);
    vec_t v;
    v.rst  = rs[0];
    v.start = st[0];
    v.stop = sp[0];
    v.sv   = sv[0];
    v.sd   = DATA_W'(sd);
    v.rr   = rr[0];
    v.fd   = FEAT_W'(fd);
    v.fv   = fv[0];
    v.thr  = FEAT_W'(th);
    v.srdy = srdy[0];
    v.fen  = fen[0];
    v.frst = frst[0];
    v.fdin = DATA_W'(fdin);
    v.rv   = rv[0];
    v.rf   = FEAT_W'(rf);
    v.rd   = rd[0];
    v.bsy  = bsy[0];
    v.ovr  = ov[0];
    return v;
  endfunction

  task automatic check(input string nm, input int id, input logic [31:0] act,
                       input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s step %0d: got %0h expected %0h", nm, id, act, exp);
    end
  endtask

  // Drive one cycle of inputs, check the outputs of that cycle, advance.
  task automatic apply(input int id, input vec_t v);
    rst            = v.rst;
    start          = v.start;
    stop           = v.stop;
    bus.s_valid    = v.sv;
    bus.s_data     = v.sd;
    bus.res_ready  = v.rr;
    bus.feat_dout  = v.fd;
    bus.feat_valid = v.fv;
    threshold      = v.thr;
    #1;
    check("s_ready",    id, 32'($unsigned(bus.s_ready)),    32'(v.srdy));
    check("feat_en",    id, 32'($unsigned(bus.feat_en)),    32'(v.fen));
    check("feat_rst",   id, 32'($unsigned(bus.feat_rst)),   32'(v.frst));
    check("feat_din",   id, 32'($unsigned(bus.feat_din)),   32'(v.fdin));
    check("res_valid",  id, 32'($unsigned(bus.res_valid)),  32'(v.rv));
    check("res_feat",   id, 32'($unsigned(bus.res_feat)),   32'(v.rf));
    check("res_detect", id, 32'($unsigned(bus.res_detect)), 32'(v.rd));
    check("busy",       id, 32'($unsigned(busy)),           32'(v.bsy));
    check("overrun",    id, 32'($unsigned(overrun)),        32'(v.ovr));
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;

    // rst srt stp sv sd rr fd fv thr | srdy fen frst din rv rf rd bsy ovr
    // idle after reset, s_valid high must not be accepted; stop ignored
    for (int i = 0; i < 5; i++) vec[i] = mk(0,0,0,1,7,0,100,1,50, 0,1,0,0, 0,0,0,0,0);
    vec[5]  = mk(0,0,1,1,7,0,100,1,50, 0,1,0,0, 0,0,0,0,0);
    vec[6]  = mk(0,1,0,0,0,0,100,1,50, 0,1,0,0, 0,0,0,0,0);
    // CLEAR: single feat_rst cycle
    vec[7]  = mk(0,0,0,0,0,0,100,1,50, 0,1,1,0, 0,0,0,1,0);
    // four back-to-back samples
    for (int i = 0; i < 4; i++)
      vec[8+i] = mk(0,0,0,1,10*(i+1),0,100,1,50, 1,0,0,10*(i+1), 0,0,0,1,0);
    // DRAIN x2 then CAPTURE (100 > 50)
    for (int i = 0; i < 3; i++) vec[12+i] = mk(0,0,0,1,99,0,100,1,50, 0,1,0,40, 0,0,0,1,0);
    // next window, first sample 4 cycles after the last; s_valid 1,0,0,1,1,0,1
    vec[15] = mk(0,0,0,1,5,0,100,1,50, 1,0,0,5, 1,100,1,1,0);
    vec[16] = mk(0,0,0,0,0,0,100,1,50, 1,1,0,5, 1,100,1,1,0);
    vec[17] = mk(0,0,0,0,0,0,100,1,50, 1,1,0,5, 1,100,1,1,0);
    vec[18] = mk(0,0,0,1,6,0,100,1,50, 1,0,0,6, 1,100,1,1,0);
    vec[19] = mk(0,0,0,1,7,0,100,1,50, 1,0,0,7, 1,100,1,1,0);
    vec[20] = mk(0,0,0,0,0,0,100,1,50, 1,1,0,7, 1,100,1,1,0);
    vec[21] = mk(0,0,0,1,8,0,100,1,50, 1,0,0,8, 1,100,1,1,0);
    // DRAIN, then capture -3 vs -3 (equal -> no detect) with res_ready=1
    vec[22] = mk(0,0,0,1,9,0,-3,1,-3, 0,1,0,8, 1,100,1,1,0);
    vec[23] = mk(0,0,0,1,9,0,-3,1,-3, 0,1,0,8, 1,100,1,1,0);
    vec[24] = mk(0,0,0,0,0,1,-3,1,-3, 0,1,0,8, 1,100,1,1,0);
    vec[25] = mk(0,0,0,0,0,0,-2,1,-3, 1,1,0,8, 1,-3,0,1,0);
    // window held unaccepted: capture -2 vs -3 overwrites and sets overrun
    for (int i = 0; i < 4; i++)
      vec[26+i] = mk(0,0,0,1,i+1,0,-2,1,-3, 1,0,0,i+1, 1,-3,0,1,0);
    for (int i = 0; i < 3; i++) vec[30+i] = mk(0,0,0,0,0,0,-2,1,-3, 0,1,0,4, 1,-3,0,1,0);
    vec[33] = mk(0,0,0,0,0,0,-2,1,-3, 1,1,0,4, 1,-2,1,1,1);
    vec[34] = mk(0,0,0,0,0,1,-2,1,-3, 1,1,0,4, 1,-2,1,1,1);
    vec[35] = mk(0,0,0,0,0,0,-2,1,-3, 1,1,0,4, 0,-2,1,1,1);

    rst = 1'b1; start = 1'b0; stop = 1'b0; threshold = '0;
    bus.s_valid = 1'b1; bus.s_data = '0; bus.res_ready = 1'b0;
    bus.feat_dout = '0; bus.feat_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);

    for (int i = 0; i < 36; i++) apply(i, vec[i]);

    // Stop mid-window: the window still completes, captures, then IDLE.
    apply(200, mk(0,0,0,1,11,0,77,1,80, 1,0,0,11, 0,-2,1,1,1));
    apply(201, mk(0,0,1,1,12,0,77,1,80, 1,0,0,12, 0,-2,1,1,1));
    apply(202, mk(0,0,0,0,0,0,77,1,80, 1,1,0,12, 0,-2,1,1,1));
    apply(203, mk(0,0,0,1,13,0,77,1,80, 1,0,0,13, 0,-2,1,1,1));
    apply(204, mk(0,0,0,1,14,0,77,1,80, 1,0,0,14, 0,-2,1,1,1));
    for (int i = 0; i < 3; i++)
      apply(205+i, mk(0,0,0,0,0,0,77,1,80, 0,1,0,14, 0,-2,1,1,1));
    for (int i = 0; i < 2; i++)
      apply(208+i, mk(0,0,0,1,15,0,77,1,80, 0,1,0,14, 1,77,0,0,1));

    // Capture with feat_valid low leaves the held result untouched.
    apply(300, mk(0,1,0,0,0,0,77,1,80, 0,1,0,14, 1,77,0,0,1));
    apply(301, mk(0,0,0,0,0,0,555,0,80, 0,1,1,14, 1,77,0,1,1));
    for (int i = 0; i < 4; i++)
      apply(302+i, mk(0,0,0,1,21+i,0,555,0,80, 1,0,0,21+i, 1,77,0,1,1));
    for (int i = 0; i < 3; i++)
      apply(306+i, mk(0,0,0,0,0,0,555,0,80, 0,1,0,24, 1,77,0,1,1));
    apply(309, mk(0,0,0,0,0,0,555,0,80, 1,1,0,24, 1,77,0,1,1));

    // Reset in DRAIN aborts; the pending capture never appears.
    for (int i = 0; i < 4; i++)
      apply(400+i, mk(0,0,0,1,31+i,0,555,1,80, 1,0,0,31+i, 1,77,0,1,1));
    apply(404, mk(1,0,0,0,0,0,555,1,80, 0,1,0,34, 1,77,0,1,1));
    for (int i = 0; i < 4; i++)
      apply(405+i, mk(0,0,0,1,40,0,555,1,80, 0,1,0,0, 0,0,0,0,0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/ll_ctrl.md
Name: ll_ctrl

Overview:
- Sequencing controller for the line-length feature datapath.
- Accepts a valid/ready sample stream and gates the datapath's active-low enable one cycle per accepted sample.
- Counts samples into fixed-length windows. At each window boundary it waits out the datapath latency, captures the feature value, compares it against a programmable threshold, and presents the result on a valid/ready output port.
- Sits between the sample front end and the classifier or result FIFO.

Parameters:
- DATA_W, 16, sample width (signed).
- FEAT_W, 25, feature width from the datapath (signed).
- WIN_LEN, 50, samples per window.
- PIPE_LAT, 2, cycles from the last window sample to a stable datapath output.
- CNT_W, 6, sample-counter width; must satisfy 2^CNT_W > WIN_LEN.

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- start  in  1  single-cycle pulse; begins streaming from IDLE.
- stop  in  1  single-cycle pulse; latched; streaming halts at the next window boundary.
- threshold  in  FEAT_W  signed detection threshold; sampled at each capture.
- s_valid  in  1  input sample valid.
- s_ready  out  1  controller accepts a sample this cycle.
- s_data  in  DATA_W  input sample.
- feat_en  out  1  datapath enable, active-low.
- feat_rst  out  1  datapath reset, active-high.
- feat_din  out  DATA_W  sample to the datapath.
- feat_dout  in  FEAT_W  datapath feature value.
- feat_valid  in  1  datapath output-valid flag.
- res_valid  out  1  result available.
- res_ready  in  1  downstream accepts the result.
- res_feat  out  FEAT_W  captured feature value.
- res_detect  out  1  asserted when res_feat > threshold (signed compare).
- busy  out  1  high in any state other than IDLE.
- overrun  out  1  sticky; a result was overwritten before it was accepted.

Behaviour:
- Reset values: state=IDLE, s_ready=0, feat_en=1, feat_rst=0, feat_din=0, res_valid=0, res_feat=0, res_detect=0, overrun=0, sample counter=0, latency counter=0, stop latch=0.
- A reset asserted mid-operation aborts immediately to these values. A pending result is discarded.
- States:
  - IDLE: s_ready=0, feat_en=1. start -> CLEAR. stop in IDLE is ignored.
  - CLEAR: exactly 1 cycle with feat_rst=1 and feat_en=1. Clears the stop latch. -> RUN.
  - RUN: s_ready=1. A sample is accepted when s_valid && s_ready. That cycle: feat_en=0, feat_din=s_data, counter+1. Otherwise feat_en=1 and feat_din holds its last value. When the WIN_LEN-th sample is accepted, counter->0 -> DRAIN.
  - DRAIN: s_ready=0, feat_en=1. Lasts exactly PIPE_LAT cycles (latency counter), then -> CAPTURE.
  - CAPTURE: 1 cycle, s_ready=0. Captures feat_dout. Next state: stop latch set -> IDLE, else -> RUN.
- Capture in CAPTURE:
  - feat_valid=1: res_feat<=feat_dout, res_detect<=(feat_dout > threshold), res_valid<=1.
  - feat_valid=0 (datapath pipeline still filling): no result is produced; res_* are unchanged.
- Latency: the first sample of the next window can be accepted PIPE_LAT+2 cycles after the last sample of the current window.
- Result handshake:
  - res_valid clears on res_valid && res_ready, unless a capture occurs in the same cycle. In that case res_valid stays 1 with the new data and overrun is not set.
  - If a capture occurs while res_valid=1 and res_ready=0: the new result overwrites the held one and overrun<=1.
  - overrun clears only on rst.
- res_feat and res_detect are stable while res_valid=1 and no capture occurs.
- stop:
  - Latched on any cycle in CLEAR/RUN/DRAIN/CAPTURE.
  - A stop pulse arriving in CLEAR is kept, not cleared.
  - Honoured only at CAPTURE; a partial window is never truncated.
- start while busy is ignored.
- Counter wrap: the sample counter never exceeds WIN_LEN-1. It resets to 0 on window completion, on entering CLEAR, and on rst.
- Threshold compare is signed, full FEAT_W. Equality gives res_detect=0.

Test Plan:
- Reset/idle: rst for 2 cycles, then 5 idle cycles with s_valid=1 -> s_ready=0, feat_en=1, busy=0, res_valid=0, overrun=0.
- Basic window (WIN_LEN=4, PIPE_LAT=2): start; feed 4 samples back-to-back; tie feat_dout=100, feat_valid=1, threshold=50 -> feat_rst pulses 1 cycle; feat_en low exactly 4 cycles; s_ready low 3 cycles; res_valid=1 with res_feat=100 and res_detect=1; the next sample is accepted 4 cycles after the 4th sample.
- Input bubbles: s_valid toggles 1,0,0,1,1,0,1 -> feat_en low only on the 4 accept cycles; DRAIN entered after the 4th accept.
- Threshold edge: feat_dout=-3, threshold=-3 -> res_detect=0. feat_dout=-2 -> res_detect=1.
- Overrun: res_ready=0 across two windows -> second capture overwrites res_feat and overrun=1. A capture coinciding with res_ready=1 -> overrun stays 0.
- Stop and abort: stop pulse mid-window -> the remaining samples of the window are accepted, the capture occurs, then IDLE. Separately, rst asserted in DRAIN -> all outputs return to reset values the next cycle and the pending result is lost.
